ext_bus_initiator: RTL

Initiator (master) side of the DSP external-bus protocol that the FPGA bus responders decode: active-low chip select, read enable and write enable, an 8-bit address and a 16-bit bidirectional data bus. The block turns a single-request handshake from internal logic into correctly sequenced bus cycles. Setup, strobe and hold lengths are programmable. It returns read data or write completion through a response pulse. It sits in a bridge/test FPGA that drives another FPGA's bus; the top level owns the db tristate pad.

---
 rtl/ext_bus_initiator.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ext_bus_initiator.sv
// ext_bus_initiator
// Initiator side of the DSP external bus: turns a single request/response
// handshake into a sequenced cs_n/re_n/we_n bus cycle with programmable
// setup, strobe and hold lengths. All bus outputs come straight from flops.
//
// Optional feature macro: BUSINIT_WAIT_EN
//   defined   -> responder wait_n stretches the strobe, with a timeout that
//                ends the cycle and flags rsp_err (reads return 16'hFFFF)
//   undefined -> wait_n is ignored, rsp_err is tied low, no timeout counter
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | bus released, req_ready high, waiting for a request
// SETUP  | cs_n low, address (and write data) driven ahead of the strobe
// STROBE | re_n or we_n low; read data captured on the exit edge
// HOLD   | strobe high again, cs_n/ab/db still held
// TURN   | cs_n high, db released, rsp_valid pulse; may accept next request

module ext_bus_initiator #(
   parameter int SETUP_CYC   = 1,
   parameter int STROBE_CYC  = 3,
   parameter int HOLD_CYC    = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        xclk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic [7:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        cs_n,
   output logic        re_n,
   output logic        we_n,
   output logic [7:0]  ab,
   output logic [15:0] db_out,
   output logic        db_oe,
   input  logic [15:0] db_in,
   input  logic        wait_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_TURN
   } state_t;

   state_t      state;
   logic        lat_rnw;
   logic [3:0]  phase_cnt;
   logic [7:0]  strobe_cnt;
   logic        accept;
   logic        strobe_exit;
   logic        strobe_err;

   assign accept = req_valid & req_ready;

`ifdef BUSINIT_WAIT_EN
   logic [7:0]  timeout_cnt;
   logic        err_q;

   // Strobe ends once the minimum has elapsed and the responder is not
   // stalling, or when the total strobe budget is used up.
   always_comb begin
      strobe_exit = (strobe_cnt == 8'd0);
      strobe_err  = 1'b0;
      if ((strobe_cnt == 8'd0) && !wait_n) begin
         if (timeout_cnt == 8'd0) begin
            strobe_err = 1'b1;
         end else begin
            strobe_exit = 1'b0;
         end
      end
   end
`else
   logic        unused_cfg;

   // Without wait support the strobe length is fixed.
   always_comb begin
      strobe_exit = (strobe_cnt == 8'd0);
      strobe_err  = 1'b0;
   end

   assign rsp_err    = 1'b0;
   assign unused_cfg = ^{wait_n, 8'(TIMEOUT_CYC)};
`endif

   // Bus-cycle sequencer: state, phase counters and every registered output.
   // TURN already has cs_n high and db released, so a request taken there
   // goes straight to SETUP, giving exactly one cs_n-high cycle between
   // back-to-back transactions.
   always_ff @(posedge xclk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         req_ready   <= 1'b0;
         lat_rnw     <= 1'b0;
         phase_cnt   <= 4'd0;
         strobe_cnt  <= 8'd0;
         cs_n        <= 1'b1;
         re_n        <= 1'b1;
         we_n        <= 1'b1;
         ab          <= 8'd0;
         db_out      <= 16'd0;
         db_oe       <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 16'd0;
`ifdef BUSINIT_WAIT_EN
         timeout_cnt <= 8'd0;
         err_q       <= 1'b0;
         rsp_err     <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE, S_TURN: begin
               if (accept) begin
                  state     <= S_SETUP;
                  req_ready <= 1'b0;
                  lat_rnw   <= req_rnw;
                  phase_cnt <= 4'(SETUP_CYC - 1);
                  cs_n      <= 1'b0;
                  ab        <= req_addr;
                  if (!req_rnw) begin
                     db_out <= req_wdata;
                     db_oe  <= 1'b1;
                  end
               end else begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
               end
            end

            S_SETUP: begin
               if (phase_cnt == 4'd0) begin
                  state      <= S_STROBE;
                  strobe_cnt <= 8'(STROBE_CYC - 1);
`ifdef BUSINIT_WAIT_EN
                  timeout_cnt <= 8'(TIMEOUT_CYC - 1);
`endif
                  if (lat_rnw) begin
                     re_n <= 1'b0;
                  end else begin
                     we_n <= 1'b0;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end

            S_STROBE: begin
               if (strobe_exit) begin
                  state     <= S_HOLD;
                  phase_cnt <= 4'(HOLD_CYC - 1);
                  re_n      <= 1'b1;
                  we_n      <= 1'b1;
                  if (lat_rnw) begin
                     rsp_rdata <= strobe_err ? 16'hFFFF : db_in;
                  end
`ifdef BUSINIT_WAIT_EN
                  err_q <= strobe_err;
`endif
               end else begin
                  if (strobe_cnt != 8'd0) begin
                     strobe_cnt <= strobe_cnt - 8'd1;
                  end
`ifdef BUSINIT_WAIT_EN
                  timeout_cnt <= timeout_cnt - 8'd1;
`endif
               end
            end

            S_HOLD: begin
               if (phase_cnt == 4'd0) begin
                  state     <= S_TURN;
                  cs_n      <= 1'b1;
                  db_oe     <= 1'b0;
                  rsp_valid <= 1'b1;
                  req_ready <= 1'b1;
`ifdef BUSINIT_WAIT_EN
                  rsp_err   <= err_q;
`endif
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
